// File: rtl/fifo_pkg.sv
// Shared FIFO constants and read-side FSM state type.
// Used by the FIFO, its writer and the burst reader.
package fifo_pkg;

    localparam int FIFO_DATA_W = 8;
    localparam int FIFO_DEPTH  = 64;
    localparam int FIFO_CNT_W  = 7;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } rd_state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Small circular skid buffer between the FIFO read port and the stream.
// Same-cycle push and pop keep occupancy unchanged.
module fifo_rd_skid #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 2,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] head,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    // A full buffer may still accept a push when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst master: pops cmd_len words from the FIFO and
// streams them out on valid/ready with m_last, then pulses done.
module fifo_burst_reader
    import fifo_pkg::*;
#(
    parameter  int DATA_W = FIFO_DATA_W,
    parameter  int LEN_W  = FIFO_CNT_W,
    parameter  int RD_LAT = 1,
    parameter  int SKID_D = RD_LAT + 1,
    localparam int CNT_W  = $clog2(SKID_D + 1),
    localparam int OCC_W  = $clog2(SKID_D + RD_LAT + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              fifo_rd_en,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              done,
    output logic              busy
);

    rd_state_t         state_q;
    rd_state_t         state_d;
    logic [LEN_W-1:0]  issue_cnt;
    logic [LEN_W-1:0]  deliv_cnt;
    logic [LEN_W-1:0]  len_c;
    logic [RD_LAT-1:0] vld_pipe;
    logic [CNT_W-1:0]  skid_count;
    logic              skid_full;
    logic              skid_empty;
    logic              cap;
    logic              hs;
    logic              room;
    logic [OCC_W-1:0]  inflight;
    logic [OCC_W-1:0]  occ;

    assign len_c = (cmd_len > LEN_W'(FIFO_DEPTH)) ? LEN_W'(FIFO_DEPTH)
                                                  : cmd_len;

    assign m_valid = !skid_empty;
    assign hs      = m_valid && m_ready;
    assign m_last  = m_valid && (deliv_cnt == LEN_W'(1));
    assign cap     = vld_pipe[RD_LAT-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + OCC_W'(vld_pipe[i]);
        end
    end

    // Occupancy after this edge; a word leaving now frees its slot,
    // which is what sustains one word per cycle with a 2-entry skid.
    assign occ  = OCC_W'(skid_count) + inflight - OCC_W'(hs);
    assign room = (occ < OCC_W'(SKID_D)) && (!skid_full || hs);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        fifo_rd_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_d = (len_c == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                fifo_rd_en = (issue_cnt != '0) && !fifo_empty && room;
                if (hs && m_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            issue_cnt <= '0;
            deliv_cnt <= '0;
            vld_pipe  <= '0;
        end else begin
            vld_pipe[0] <= fifo_rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
            if (state_q == IDLE && cmd_valid) begin
                issue_cnt <= len_c;
                deliv_cnt <= len_c;
            end else begin
                if (fifo_rd_en) begin
                    issue_cnt <= issue_cnt - LEN_W'(1);
                end
                if (hs) begin
                    deliv_cnt <= deliv_cnt - LEN_W'(1);
                end
            end
        end
    end

    fifo_rd_skid #(
        .DATA_W (DATA_W),
        .DEPTH  (SKID_D)
    ) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (cap),
        .pop   (hs),
        .din   (fifo_dout),
        .head  (m_data),
        .count (skid_count),
        .full  (skid_full),
        .empty (skid_empty)
    );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a registered FIFO model.
module tb_fifo_burst_reader;

    localparam int RD_LAT = 1;
    localparam int SKID_D = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [6:0] cmd_len = '0;
    logic       fifo_rd_en;
    logic [7:0] fifo_dout = '0;
    logic       fifo_empty;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic       m_last;
    logic       done;
    logic       busy;

    fifo_burst_reader #(
        .RD_LAT (RD_LAT),
        .SKID_D (SKID_D)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .fifo_rd_en (fifo_rd_en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [512];
    int wr_cnt = 0;
    int rd_cnt = 0;
    int cyc = 0;

    assign fifo_empty = (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= mem[rd_cnt];
            rd_cnt    <= rd_cnt + 1;
        end
    end

    logic [7:0] rx_data [$];
    logic       rx_last [$];
    int         rx_cyc  [$];
    int rden_cnt = 0;
    int valid_cnt = 0;
    int done_cnt = 0;
    int viol_empty = 0;
    int stall_viol = 0;
    int out_cnt = 0;
    int max_out = 0;
    logic       stall = 1'b0;
    logic [7:0] stall_data = '0;

    always @(negedge clk) begin
        if (!rst) begin
            out_cnt = 0;
            stall   = 1'b0;
        end else begin
            if (fifo_rd_en) begin
                rden_cnt++;
                if (fifo_empty) viol_empty++;
            end
            if (m_valid) valid_cnt++;
            if (done) done_cnt++;
            if (stall && !(m_valid && m_data == stall_data)) stall_viol++;
            stall      = m_valid && !m_ready;
            stall_data = m_data;
            if (m_valid && m_ready) begin
                rx_data.push_back(m_data);
                rx_last.push_back(m_last);
                rx_cyc.push_back(cyc);
            end
            out_cnt += int'(fifo_rd_en && !fifo_empty) - int'(m_valid && m_ready);
            if (out_cnt > max_out) max_out = out_cnt;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_wr(input logic [7:0] v);
        mem[wr_cnt] = v;
        wr_cnt++;
    endtask

    int hs_cyc;

    task automatic send_cmd(input string tag, input logic [6:0] len);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        cmd_len   = len;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        hs_cyc    = cyc;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int d0 = done_cnt;
        int i;
        for (i = 0; i < bound; i++) begin
            tick();
            if (done_cnt > d0) break;
        end
        check({tag, "_done_seen"}, done_cnt - d0, 1);
    endtask

    task automatic check_burst(input string tag, input int b,
                               input int first, input int n);
        int mism = 0;
        int nl = 0;
        check({tag, "_cnt"}, rx_data.size() - b, n);
        for (int i = 0; i < n; i++) begin
            if (b + i >= rx_data.size()) begin
                mism++;
            end else begin
                if (rx_data[b+i] !== 8'(first + i)) mism++;
                if (rx_last[b+i]) nl++;
            end
        end
        check({tag, "_order"}, mism, 0);
        check({tag, "_last_n"}, nl, 1);
        check({tag, "_last_pos"},
              (b + n - 1 < rx_data.size()) ? rx_last[b+n-1] : 1'b0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int b;
        int r0;
        int v0;
        int d0;
        logic [3:0] pat;

        for (int i = 0; i < 64; i++) fifo_wr(8'(i));
        repeat (3) tick();
        check("rst_ctl", {cmd_ready, busy, m_valid, fifo_rd_en, m_last, done},
              6'b100000);
        check("rst_data", m_data, 0);
        rst = 1'b1;
        tick();

        // Full 64-word burst, sink always ready.
        b  = rx_data.size();
        r0 = rden_cnt;
        d0 = done_cnt;
        send_cmd("t1", 7'd64);
        check("t1_busy", busy, 1);
        wait_done("t1", 200);
        check_burst("t1", b, 0, 64);
        check("t1_latency", rx_cyc[b] - hs_cyc, RD_LAT + 1);
        check("t1_back2back", rx_cyc[b+63] - rx_cyc[b], 63);
        check("t1_rden", rden_cnt - r0, 64);
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_fifo_empty", fifo_empty, 1);
        tick();
        check("t1_idle", {busy, cmd_ready}, 2'b01);

        // Zero-length command.
        b  = rx_data.size();
        r0 = rden_cnt;
        v0 = valid_cnt;
        send_cmd("t2", 7'd0);
        check("t2_done_now", {done, busy, cmd_ready}, 3'b110);
        tick();
        check("t2_after", {done, busy, cmd_ready}, 3'b001);
        check("t2_rden", rden_cnt - r0, 0);
        check("t2_valid", valid_cnt - v0, 0);

        // FIFO runs dry mid-burst, refilled later.
        fifo_wr(8'd10);
        fifo_wr(8'd11);
        fifo_wr(8'd12);
        b  = rx_data.size();
        r0 = rden_cnt;
        send_cmd("t3", 7'd5);
        repeat (15) tick();
        check("t3_part_cnt", rx_data.size() - b, 3);
        check("t3_part_rden", rden_cnt - r0, 3);
        check("t3_stalled", {busy, m_valid, fifo_rd_en}, 3'b100);
        fifo_wr(8'd13);
        tick();
        fifo_wr(8'd14);
        wait_done("t3", 50);
        check_burst("t3", b, 10, 5);
        check("t3_no_empty_pop", viol_empty, 0);

        // Back-pressure pattern 1,0,0,1.
        for (int i = 0; i < 20; i++) fifo_wr(8'(100 + i));
        b   = rx_data.size();
        d0  = done_cnt;
        pat = 4'b1001;
        send_cmd("t4", 7'd20);
        for (int c = 0; c < 300; c++) begin
            m_ready = pat[c%4];
            tick();
            if (done_cnt > d0) break;
        end
        m_ready = 1'b1;
        check("t4_done_seen", done_cnt - d0, 1);
        check_burst("t4", b, 100, 20);
        check("t4_stable", stall_viol, 0);
        check("t4_skid_bound", max_out <= SKID_D, 1);
        tick();

        // Reset while the 5th word of a 32-word burst is on the stream.
        for (int i = 0; i < 32; i++) fifo_wr(8'(200 + i));
        b = rx_data.size();
        send_cmd("t5", 7'd32);
        for (int i = 0; i < 100 && rx_data.size() - b < 4; i++) tick();
        check("t5_reach", rx_data.size() - b, 4);
        check("t5_word5", {m_valid, m_data}, {1'b1, 8'd204});
        rst = 1'b0;
        tick();
        check("t5_rst_ctl", {cmd_ready, busy, m_valid, fifo_rd_en, m_last, done},
              6'b100000);
        check("t5_rst_data", m_data, 0);
        rst = 1'b1;
        tick();
        b = rx_data.size();
        send_cmd("t5b", 7'd2);
        wait_done("t5b", 50);
        check_burst("t5b", b, 207, 2);
        tick();

        // Command during RUN is ignored.
        b  = rx_data.size();
        r0 = rden_cnt;
        send_cmd("t6", 7'd10);
        cmd_len   = 7'd9;
        cmd_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done) break;
        end
        check("t6_done", done, 1);
        cmd_valid = 1'b0;
        repeat (3) tick();
        check_burst("t6", b, 209, 10);
        check("t6_rden", rden_cnt - r0, 10);
        check("t6_fifo_level", wr_cnt - rd_cnt, 13);
        check("t6_idle", {busy, cmd_ready}, 2'b01);

        check("no_empty_pop", viol_empty, 0);
        check("skid_bound", max_out <= SKID_D, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
